hbmc_elastic_fifo: RTL and testbench
====================================

HBMC_ELASTIC_FIFO -- requirements
Module: hbmc_elastic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, storage depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter START_LEVEL, default 2, fill level (1..DEPTH) required before output starts.
REQ-004 SHALL have parameter REPRIME, default 1; 1 = return to pre-fill on drain-out, 0 = keep running.
REQ-005 SHALL have ports: clk input 1, single clock for all logic.
REQ-006 SHALL have ports: arst input 1, asynchronous active-high reset.
REQ-007 SHALL have ports: clear input 1, synchronous flush.
REQ-008 SHALL have ports: din_valid input 1 and din input DATA_WIDTH, write request and data.
REQ-009 SHALL have ports: din_ready output 1, write accepted when din_valid & din_ready.
REQ-010 SHALL have ports: dout output DATA_WIDTH (registered) and dout_valid output 1, read data and qualifier.
REQ-011 SHALL have ports: dout_ready input 1, read consumed when dout_valid & dout_ready.
REQ-012 SHALL have ports: level output ADDR_WIDTH+1, words held, including the one on dout.
REQ-013 SHALL have ports: running output 1, high in RUN state.
REQ-014 SHALL have ports: overflow output 1 and underflow output 1, sticky error flags.

Function
REQ-015 SHALL keep write/read pointers ADDR_WIDTH+1 bits wide, with the MSB as wrap bit; address wraps DEPTH-1 -> 0 without a gap.
REQ-016 SHALL drive din_ready = (level < DEPTH), from registered state only; a write is refused when full, even with a simultaneous read.
REQ-017 SHALL change level by +1 on write only, -1 on read only, and 0 on simultaneous write and read.
REQ-018 SHALL implement state machine FILL -> RUN when level >= START_LEVEL; dout_valid forced 0 in FILL.
REQ-019 SHALL, in RUN, assert dout_valid whenever the output register holds a word.
REQ-020 SHALL, in RUN with level reaching 0: REPRIME=1 -> FILL; REPRIME=0 -> stay RUN.
REQ-021 SHALL present a word accepted on edge k on dout no earlier than after edge k+1; with buffer empty, RUN and START_LEVEL satisfied, exactly after edge k+1.
REQ-022 SHALL keep dout stable while dout_valid & ~dout_ready.
REQ-023 SHALL present words in write order, with no loss or duplication across pointer wrap.
REQ-024 SHALL set overflow on any cycle with din_valid & ~din_ready, holding it until clear or arst.
REQ-025 SHALL set underflow on any RUN cycle with dout_ready & ~dout_valid, holding it until clear or arst.
REQ-026 SHALL, on clear: zero pointers and level, set state FILL, drop dout_valid, and clear both flags; clear overrides a same-cycle write/read, whose data is discarded.

Reset
REQ-027 SHALL, while arst is high: pointers = 0, level = 0, state = FILL, dout = 0, dout_valid = 0, din_ready = 0, overflow = 0, underflow = 0.
REQ-028 SHALL raise din_ready on the first edge after arst deasserts; storage contents are not reset.
REQ-029 SHALL have arst mid-transfer abort all words and return outputs to reset values asynchronously; the caller synchronizes arst release.

Structure
REQ-030 SHALL take the state encoding (FILL, RUN) and a level-width constant/function from shared package hbmc_elastic_pkg.
REQ-031 SHALL hold storage in one sub-module hbmc_sdp_ram: single-clock, one write port, one read port, no reset, inferable as distributed/block RAM.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, START_LEVEL=4, REPRIME=1)
REQ-032 SHALL check pre-fill: write 0x01..0x04, dout_ready=1 -> dout_valid low until level=4, then 0x01..0x04 in order, running=1, then FILL on empty.
REQ-033 SHALL check full/overflow: write 17 words with no reads -> din_ready low after 16th, level=16, overflow=1, 17th word never appears.
REQ-034 SHALL check streaming and wrap: continuous write+read of 0x00..0x63 after priming -> level constant at 4, all 100 words in order, no flags.
REQ-035 SHALL check underflow and REPRIME=0: stop writes in RUN, hold dout_ready=1 -> drains to level 0, underflow=1, running stays 1.
REQ-036 SHALL check clear vs arst: clear asserted with write and level=9 -> next cycle level=0, dout_valid=0, flags 0; arst pulse mid-burst -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hbmc_elastic_pkg.sv
// Shared definitions for the elastic FIFO: state encoding and level-width helper.
package hbmc_elastic_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } fifo_state_e;

    // A level counter must represent 0..DEPTH inclusive.
    function automatic int level_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/hbmc_sdp_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port, no reset.
module hbmc_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hbmc_elastic_fifo.sv
// Elastic FIFO with pre-fill threshold: output is withheld until START_LEVEL words are buffered.
module hbmc_elastic_fifo
    import hbmc_elastic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int START_LEVEL = 2,
    parameter int REPRIME     = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  clear,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  running,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int LW    = level_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    fifo_state_e           state_q, state_d;
    logic [LW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
    logic [LW-1:0]         ram_cnt;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rdata;
    logic                  out_full_q, out_full_d, dout_valid_q, dout_valid_d;
    logic                  din_ready_q, din_ready_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_en, pop, load, ram_we;

    always_comb begin
        wr_en        = din_valid & din_ready_q;
        pop          = dout_valid_q & dout_ready;
        ram_cnt      = wr_ptr_q - rd_ptr_q;
        // The output register refills from RAM whenever it is empty or being drained.
        load         = (ram_cnt != '0) & (~out_full_q | pop);
        ram_we       = wr_en & ~clear;
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        dout_d       = dout_q;
        out_full_d   = out_full_q;
        dout_valid_d = dout_valid_q;
        din_ready_d  = din_ready_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        if (clear) begin
            state_d      = ST_FILL;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            out_full_d   = 1'b0;
            dout_valid_d = 1'b0;
            din_ready_d  = 1'b1;
            ovf_d        = 1'b0;
            unf_d        = 1'b0;
        end else begin
            wr_ptr_d   = wr_ptr_q + LW'(wr_en);
            rd_ptr_d   = rd_ptr_q + LW'(load);
            level_d    = level_q + LW'(wr_en) - LW'(pop);
            out_full_d = load | (out_full_q & ~pop);
            if (load) dout_d = ram_rdata;
            case (state_q)
                ST_FILL: if (level_d >= LW'(START_LEVEL)) state_d = ST_RUN;
                ST_RUN:  if ((REPRIME != 0) && (level_d == '0)) state_d = ST_FILL;
                default: state_d = ST_FILL;
            endcase
            dout_valid_d = (state_d == ST_RUN) & out_full_d;
            din_ready_d  = level_d < LW'(DEPTH);
            ovf_d        = ovf_q | (din_valid & ~din_ready_q);
            unf_d        = unf_q | ((state_q == ST_RUN) & dout_ready & ~dout_valid_q);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dout_q       <= '0;
            out_full_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dout_q       <= dout_d;
            out_full_q   <= out_full_d;
            dout_valid_q <= dout_valid_d;
            din_ready_q  <= din_ready_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    hbmc_sdp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata(din),
        .raddr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata(ram_rdata)
    );

    assign din_ready  = din_ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign level      = level_q;
    assign running    = (state_q == ST_RUN);
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_hbmc_elastic_fifo.sv
// Bench for hbmc_elastic_fifo: queue-based reference model plus directed scenarios.
module tb_hbmc_elastic_fifo;

    localparam int DEPTH = 16;
    localparam int START = 4;

    logic       clk = 1'b0;
    logic       arst, clear, din_valid, dout_ready;
    logic [7:0] din;
    logic       din_ready, dout_valid, running, overflow, underflow;
    logic [7:0] dout;
    logic [4:0] level;
    logic       din_ready0, dout_valid0, running0, overflow0, underflow0;
    logic [7:0] dout0;
    logic [4:0] level0;

    int errors = 0;
    int checks = 0;

    // Reference model: every word held (including the one on dout), with the edge it was written on.
    logic [7:0] mq[$];
    int         mw[$];
    bit         run_m, ovf_m, unf_m, blk_m;
    int         edge_n = 0;

    hbmc_elastic_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_LEVEL(START), .REPRIME(1)) u_dut (
        .clk(clk), .arst(arst), .clear(clear), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .level(level), .running(running), .overflow(overflow), .underflow(underflow));

    hbmc_elastic_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_LEVEL(START), .REPRIME(0)) u_dut0 (
        .clk(clk), .arst(arst), .clear(clear), .din_valid(din_valid), .din(din),
        .din_ready(din_ready0), .dout(dout0), .dout_valid(dout_valid0), .dout_ready(dout_ready),
        .level(level0), .running(running0), .overflow(overflow0), .underflow(underflow0));

    always #5 clk = ~clk;

    // A word written on edge e is presentable once edge e+1 has passed and the FIFO runs.
    function automatic bit m_vis();
        if (!run_m || mq.size() == 0) return 1'b0;
        return (mw[0] + 2) <= edge_n;
    endfunction

    function automatic bit m_rdy();
        return !blk_m && (mq.size() < DEPTH);
    endfunction

    task automatic m_reset();
        mq.delete();
        mw.delete();
        run_m = 0; ovf_m = 0; unf_m = 0; blk_m = 1;
    endtask

    // Advance one clock edge, applying the current inputs to the model.
    task automatic tick();
        bit rdy, vis;
        rdy = m_rdy();
        vis = m_vis();
        if (clear) begin
            mq.delete(); mw.delete();
            run_m = 0; ovf_m = 0; unf_m = 0;
        end else begin
            if (din_valid && !rdy) ovf_m = 1;
            if (run_m && dout_ready && !vis) unf_m = 1;
            if (vis && dout_ready) begin
                void'(mq.pop_front());
                void'(mw.pop_front());
            end
            if (din_valid && rdy) begin
                mq.push_back(din);
                mw.push_back(edge_n);
            end
            if (!run_m && mq.size() >= START) run_m = 1;
            else if (run_m && mq.size() == 0) run_m = 0;
        end
        blk_m = 0;
        edge_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1; din_valid = 0; dout_ready = 0;
        tick();
        clear = 0;
    endtask

    task automatic test_reset();
        arst = 1; clear = 0; din_valid = 0; dout_ready = 0; din = '0;
        m_reset();
        #3;
        checks++;
        if ({dout_valid, din_ready, running, overflow, underflow} !== 5'b0 || level !== 5'd0 || dout !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b r=%b run=%b o=%b u=%b lvl=%0d dout=%h exp all zero",
                     dout_valid, din_ready, running, overflow, underflow, level, dout);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst = 0;
        #1;
        checks++;
        if (din_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rdy_before_edge got=%b exp=0", din_ready);
        end
        tick();
        checks++;
        if (din_ready !== 1'b1 || level !== 5'd0) begin
            errors++; $display("FAIL reset_rdy_after_edge got rdy=%b lvl=%0d exp rdy=1 lvl=0", din_ready, level);
        end
    endtask

    task automatic test_prefill();
        logic [7:0] got[$];
        dout_ready = 1;
        for (int i = 1; i <= 12; i++) begin
            din_valid = (i <= 4);
            din = 8'(i);
            if (dout_valid && dout_ready) got.push_back(dout);
            tick();
            checks++;
            if (dout_valid !== m_vis() || level !== 5'(mq.size())) begin
                errors++;
                $display("FAIL prefill_step%0d got v=%b lvl=%0d exp v=%b lvl=%0d", i, dout_valid, level, m_vis(), mq.size());
            end
            if (i == 4) begin
                checks++;
                if (running !== 1'b1 || dout_valid !== 1'b1 || dout !== 8'h01) begin
                    errors++;
                    $display("FAIL prefill_start got run=%b v=%b dout=%h exp run=1 v=1 dout=01", running, dout_valid, dout);
                end
            end
        end
        din_valid = 0;
        checks++;
        if (got.size() != 4 || got[0] !== 8'h01 || got[1] !== 8'h02 || got[2] !== 8'h03 || got[3] !== 8'h04) begin
            errors++; $display("FAIL prefill_order got n=%0d data=%p exp 01 02 03 04", got.size(), got);
        end
        checks++;
        if (running !== 1'b0 || level !== 5'd0) begin
            errors++; $display("FAIL prefill_refill got run=%b lvl=%0d exp run=0 lvl=0", running, level);
        end
    endtask

    task automatic test_full();
        logic [7:0] sent[17];
        logic [7:0] got[$];
        do_clear();
        for (int i = 0; i < 17; i++) begin
            sent[i] = 8'($urandom);
            din_valid = 1; din = sent[i];
            tick();
            checks++;
            if (din_ready !== (i < 15)) begin
                errors++; $display("FAIL full_ready_w%0d got=%b exp=%b", i + 1, din_ready, (i < 15));
            end
        end
        din_valid = 0;
        checks++;
        if (level !== 5'd16 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++; $display("FAIL full_state got lvl=%0d ovf=%b unf=%b exp lvl=16 ovf=1 unf=0", level, overflow, underflow);
        end
        dout_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (dout_valid) got.push_back(dout);
            tick();
        end
        dout_ready = 0;
        checks++;
        if (got.size() != 16) begin
            errors++; $display("FAIL full_count got=%0d exp=16", got.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (got[i] !== sent[i]) begin
                    errors++; $display("FAIL full_data%0d got=%h exp=%h", i, got[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [7:0] got[$];
        int d = 0;
        int steady_bad = 0;
        bit steady;
        do_clear();
        for (int cyc = 0; cyc < 200 && d < 100; cyc++) begin
            din_valid = 1; din = 8'(d);
            dout_ready = running;
            steady = running;
            if (dout_valid && dout_ready) got.push_back(dout);
            if (din_ready) d++;
            tick();
            if (steady && level !== 5'd4) steady_bad++;
        end
        din_valid = 0; dout_ready = 1;
        for (int i = 0; i < 20; i++) begin
            if (dout_valid) got.push_back(dout);
            tick();
        end
        dout_ready = 0;
        checks++;
        if (steady_bad != 0) begin
            errors++; $display("FAIL stream_level got %0d cycles off level 4 exp 0", steady_bad);
        end
        checks++;
        if (got.size() != 100) begin
            errors++; $display("FAIL stream_count got=%0d exp=100", got.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                checks++;
                if (got[i] !== 8'(i)) begin
                    errors++; $display("FAIL stream_data%0d got=%h exp=%h", i, got[i], 8'(i));
                end
            end
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++; $display("FAIL stream_flags got ovf=%b unf=%b exp 0 0", overflow, underflow);
        end
    endtask

    task automatic test_reprime0();
        logic [7:0] got[$];
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            din_valid = 1; din = 8'(8'h10 + i);
            tick();
        end
        din_valid = 0;
        checks++;
        if (running0 !== 1'b1 || level0 !== 5'd4) begin
            errors++; $display("FAIL rp0_start got run=%b lvl=%0d exp run=1 lvl=4", running0, level0);
        end
        dout_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (dout_valid0) got.push_back(dout0);
            tick();
        end
        dout_ready = 0;
        checks++;
        if (got.size() != 4 || got[0] !== 8'h11 || got[3] !== 8'h14) begin
            errors++; $display("FAIL rp0_data got n=%0d data=%p exp 11 12 13 14", got.size(), got);
        end
        checks++;
        if (level0 !== 5'd0 || underflow0 !== 1'b1 || running0 !== 1'b1 || overflow0 !== 1'b0) begin
            errors++;
            $display("FAIL rp0_drain got lvl=%0d unf=%b run=%b ovf=%b exp lvl=0 unf=1 run=1 ovf=0",
                     level0, underflow0, running0, overflow0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            din_valid  = ($urandom_range(0, 99) < 60);
            dout_ready = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 75));
            clear      = ($urandom_range(0, 99) < 2);
            din        = 8'($urandom);
            tick();
            clear = 0;
            checks++;
            if (dout_valid !== m_vis() || (m_vis() && dout !== mq[0])) begin
                errors++;
                $display("FAIL rnd_out c%0d got v=%b d=%h exp v=%b d=%h", i, dout_valid, dout, m_vis(),
                         (mq.size() > 0) ? mq[0] : 8'h00);
            end
            checks++;
            if (level !== 5'(mq.size()) || din_ready !== m_rdy() || running !== run_m) begin
                errors++;
                $display("FAIL rnd_ctl c%0d got lvl=%0d rdy=%b run=%b exp lvl=%0d rdy=%b run=%b", i,
                         level, din_ready, running, mq.size(), m_rdy(), run_m);
            end
            checks++;
            if (overflow !== ovf_m || underflow !== unf_m) begin
                errors++;
                $display("FAIL rnd_flags c%0d got ovf=%b unf=%b exp ovf=%b unf=%b", i, overflow, underflow, ovf_m, unf_m);
            end
        end
        din_valid = 0; dout_ready = 0;
    endtask

    task automatic test_clear_arst();
        do_clear();
        for (int i = 0; i < 17; i++) begin
            din_valid = 1; din = 8'(i);
            tick();
        end
        din_valid = 0; dout_ready = 1;
        repeat (7) tick();
        dout_ready = 0;
        checks++;
        if (level !== 5'd9 || overflow !== 1'b1) begin
            errors++; $display("FAIL clr_setup got lvl=%0d ovf=%b exp lvl=9 ovf=1", level, overflow);
        end
        clear = 1; din_valid = 1; din = 8'hAA;
        tick();
        clear = 0; din_valid = 0;
        checks++;
        if (level !== 5'd0 || dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL clr_result got lvl=%0d v=%b ovf=%b unf=%b run=%b exp all 0",
                     level, dout_valid, overflow, underflow, running);
        end
        dout_ready = 1;
        for (int i = 0; i < 8; i++) begin
            din_valid = 1; din = 8'(8'h40 + i);
            tick();
        end
        checks++;
        if (dout_valid !== 1'b1) begin
            errors++; $display("FAIL arst_burst_active got v=%b exp=1", dout_valid);
        end
        #2;
        arst = 1; din_valid = 0; dout_ready = 0;
        #1;
        checks++;
        if ({dout_valid, din_ready, running, overflow, underflow} !== 5'b0 || level !== 5'd0 || dout !== 8'd0) begin
            errors++;
            $display("FAIL arst_async got v=%b r=%b run=%b o=%b u=%b lvl=%0d dout=%h exp all zero",
                     dout_valid, din_ready, running, overflow, underflow, level, dout);
        end
        @(posedge clk);
        @(negedge clk);
        arst = 0;
        m_reset();
        tick();
        checks++;
        if (din_ready !== 1'b1 || level !== 5'd0 || dout_valid !== 1'b0) begin
            errors++; $display("FAIL arst_release got rdy=%b lvl=%0d v=%b exp rdy=1 lvl=0 v=0", din_ready, level, dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_full();
        test_stream();
        test_reprime0();
        test_random();
        test_clear_arst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
